// File: rtl/mem_access.sv
// Load/store stage: decodes memory ops, runs one bus access with a bounded wait,
// and serves switch/LED I/O directly when the MMIO address bit is set.
module mem_access #(
  parameter int ADDR_W   = 32,
  parameter int SWITCH_N = 16,
  parameter int LED_N    = 16,
  parameter int MMIO_BIT = ADDR_W - 1,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic [7:0]          aluop_i,
  input  logic [4:0]          wd_i,
  input  logic                wreg_i,
  input  logic [31:0]         wdata_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [31:0]         reg2_i,
  output logic                stall_o,
  output logic                valid_o,
  output logic [4:0]          wd_o,
  output logic                wreg_o,
  output logic [31:0]         wdata_o,
  output logic                misalign_o,
  output logic                bus_err_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [3:0]          mem_sel_o,
  output logic [31:0]         mem_data_o,
  input  logic                mem_ack_i,
  input  logic [31:0]         mem_data_i,
  input  logic [SWITCH_N-1:0] switch_i,
  output logic [LED_N-1:0]    led_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       op_q;
  logic [1:0]       off_q;
  logic [4:0]       wd_q;
  logic             wreg_q;

  logic        is_load, is_store, is_byte, is_half, is_word;
  logic        is_mem, misalign, is_mmio, issue;
  logic [3:0]  sel_next;
  logic [31:0] sdata_next;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (aluop_i)
      EXE_LB_OP, EXE_LBU_OP: begin is_load  = 1'b1; is_byte = 1'b1; end
      EXE_LH_OP, EXE_LHU_OP: begin is_load  = 1'b1; is_half = 1'b1; end
      EXE_LW_OP:             begin is_load  = 1'b1; is_word = 1'b1; end
      EXE_SB_OP:             begin is_store = 1'b1; is_byte = 1'b1; end
      EXE_SH_OP:             begin is_store = 1'b1; is_half = 1'b1; end
      EXE_SW_OP:             begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
    is_mem   = is_load | is_store;
    misalign = (is_half & mem_addr_i[0]) | (is_word & (mem_addr_i[1:0] != 2'b00));
    is_mmio  = mem_addr_i[MMIO_BIT];
    issue    = (state == IDLE) & valid_i & is_mem & ~misalign & ~is_mmio;
  end

  assign stall_o = (state == BUSY) | issue;

  // Big-endian lanes: byte offset 0 lives in bits 31:24.
  always_comb begin
    sel_next   = 4'b1111;
    sdata_next = reg2_i;
    if (is_byte) begin
      sel_next   = 4'b1000 >> mem_addr_i[1:0];
      sdata_next = {4{reg2_i[7:0]}};
    end else if (is_half) begin
      sel_next   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      sdata_next = {2{reg2_i[15:0]}};
    end
  end

  always_comb begin
    lane_b = mem_data_i[31:24];
    case (off_q)
      2'd1:    lane_b = mem_data_i[23:16];
      2'd2:    lane_b = mem_data_i[15:8];
      2'd3:    lane_b = mem_data_i[7:0];
      default: lane_b = mem_data_i[31:24];
    endcase
    lane_h = off_q[1] ? mem_data_i[15:0] : mem_data_i[31:16];
    case (op_q)
      EXE_LB_OP:  load_data = {{24{lane_b[7]}}, lane_b};
      EXE_LBU_OP: load_data = {24'b0, lane_b};
      EXE_LH_OP:  load_data = {{16{lane_h[15]}}, lane_h};
      EXE_LHU_OP: load_data = {16'b0, lane_h};
      default:    load_data = mem_data_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= '0;
      off_q      <= '0;
      wd_q       <= '0;
      wreg_q     <= 1'b0;
      valid_o    <= 1'b0;
      wd_o       <= '0;
      wreg_o     <= 1'b0;
      wdata_o    <= '0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      mem_req_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_sel_o  <= '0;
      mem_data_o <= '0;
      led_o      <= '0;
    end else begin
      valid_o    <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            if (!is_mem) begin
              valid_o <= 1'b1;
              wd_o    <= wd_i;
              wreg_o  <= wreg_i;
              wdata_o <= wdata_i;
            end else if (misalign) begin
              valid_o    <= 1'b1;
              misalign_o <= 1'b1;
              wd_o       <= wd_i;
              wreg_o     <= 1'b0;
            end else if (is_mmio) begin
              valid_o <= 1'b1;
              wd_o    <= wd_i;
              if (is_load) begin
                wreg_o  <= wreg_i;
                wdata_o <= 32'(switch_i);
              end else begin
                wreg_o <= 1'b0;
                led_o  <= reg2_i[LED_N-1:0];
              end
            end else begin
              mem_req_o  <= 1'b1;
              mem_we_o   <= is_store;
              mem_addr_o <= {mem_addr_i[ADDR_W-1:2], 2'b00};
              mem_sel_o  <= sel_next;
              mem_data_o <= sdata_next;
              op_q       <= aluop_i;
              off_q      <= mem_addr_i[1:0];
              wd_q       <= wd_i;
              wreg_q     <= wreg_i & is_load;
              cnt        <= '0;
              state      <= BUSY;
            end
          end
        end
        BUSY: begin
          // Ack wins over timeout when both land in the same cycle.
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            valid_o   <= 1'b1;
            wd_o      <= wd_q;
            wreg_o    <= wreg_q;
            if (wreg_q) wdata_o <= load_data;
            state     <= IDLE;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            valid_o   <= 1'b1;
            bus_err_o <= 1'b1;
            wd_o      <= wd_q;
            wreg_o    <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomized and directed bench for mem_access against a byte-lane reference model.
module tb_mem_access;
  localparam int ADDR_W = 32, SWITCH_N = 16, LED_N = 16, TIMEOUT = 15;
  localparam logic [7:0] LB = 8'hE0, LH = 8'hE1, LW = 8'hE3, LBU = 8'hE4, LHU = 8'hE5;
  localparam logic [7:0] SB = 8'hE8, SH = 8'hE9, SW = 8'hEB, ADDU = 8'h21, ORI = 8'h25;

  logic clk, rst, valid_i, wreg_i, stall_o, valid_o, wreg_o, misalign_o, bus_err_o;
  logic mem_req_o, mem_we_o, mem_ack_i;
  logic [7:0] aluop_i;
  logic [4:0] wd_i, wd_o;
  logic [31:0] wdata_i, reg2_i, wdata_o, mem_data_o, mem_data_i;
  logic [ADDR_W-1:0] mem_addr_i, mem_addr_o;
  logic [3:0] mem_sel_o;
  logic [SWITCH_N-1:0] switch_i;
  logic [LED_N-1:0] led_o;

  mem_access #(.ADDR_W(ADDR_W), .SWITCH_N(SWITCH_N), .LED_N(LED_N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .stall_o(stall_o),
    .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o), .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .switch_i(switch_i), .led_o(led_o));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  int checks = 0, failures = 0;
  logic [15:0] led_m = '0;
  int last_stall;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ack_at: BUSY cycle index in which ack is given; negative or > TIMEOUT means never.
  task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                       input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic [15:0] sw, input logic [31:0] memw, input int ack_at);
    bit is_ld, is_st, mis, mmio, bus, acked, have_data, exp_wreg;
    int size, off, sh;
    logic [31:0] exp_sel, exp_sd, exp_wdata, val;
    is_ld = op inside {LB, LBU, LH, LHU, LW};
    is_st = op inside {SB, SH, SW};
    size  = (op inside {LB, LBU, SB}) ? 1 : (op inside {LH, LHU, SH}) ? 2 : 4;
    off   = int'(addr[1:0]);
    mis   = (is_ld || is_st) && (off % size != 0);
    mmio  = addr[31];
    bus   = (is_ld || is_st) && !mis && !mmio;
    exp_sel = (size == 1) ? (32'h8 >> off) : (size == 2) ? ((off < 2) ? 32'hC : 32'h3) : 32'hF;
    exp_sd  = (size == 1) ? reg2[7:0] * 32'h01010101 :
              (size == 2) ? reg2[15:0] * 32'h00010001 : reg2;
    sh  = 8 * (4 - size - off);
    val = (memw >> sh) & ((size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 1));
    if (op == LB && val[7])  val = val | 32'hFFFF_FF00;
    if (op == LH && val[15]) val = val | 32'hFFFF_0000;
    acked = 0;

    @(negedge clk);
    valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wd_i = wd;
    wreg_i = wreg; wdata_i = wdata; switch_i = sw; mem_ack_i = 1'b0;
    #1 check("stall_issue", 32'(stall_o), 32'(bus));
    last_stall = int'(stall_o);
    @(negedge clk);
    valid_i = 1'b0;
    if (bus) begin
      check("req", 32'(mem_req_o), 1);
      check("we", 32'(mem_we_o), 32'(is_st));
      check("addr", mem_addr_o, {addr[31:2], 2'b00});
      check("sel", 32'(mem_sel_o), exp_sel);
      check("sdata", mem_data_o, exp_sd);
      check("valid_busy", 32'(valid_o), 0);
      for (int k = 0; k <= TIMEOUT; k++) begin
        mem_ack_i  = (k == ack_at);
        mem_data_i = (k == ack_at) ? memw : $urandom;
        #1 check("stall_busy", 32'(stall_o), 1);
        check("req_hold", 32'(mem_req_o), 1);
        check("sel_hold", 32'(mem_sel_o), exp_sel);
        last_stall++;
        @(negedge clk);
        mem_ack_i = 1'b0;
        if (k == ack_at) begin acked = 1; break; end
      end
      check("req_drop", 32'(mem_req_o), 0);
    end
    exp_wreg  = 0; have_data = 0; exp_wdata = '0;
    if (!is_ld && !is_st) begin exp_wreg = wreg; have_data = 1; exp_wdata = wdata; end
    else if (!mis && mmio && is_ld) begin exp_wreg = wreg; have_data = 1; exp_wdata = {16'b0, sw}; end
    else if (bus && is_ld && acked) begin exp_wreg = wreg; have_data = wreg; exp_wdata = val; end
    if (!mis && mmio && is_st) led_m = reg2[15:0];

    check("valid", 32'(valid_o), 1);
    check("misalign", 32'(misalign_o), 32'(mis));
    check("bus_err", 32'(bus_err_o), 32'(bus && !acked));
    check("wreg", 32'(wreg_o), 32'(exp_wreg));
    check("wd", 32'(wd_o), 32'(wd));
    if (have_data) check("wdata", wdata_o, exp_wdata);
    check("led", 32'(led_o), 32'(led_m));
    if (!bus) check("no_req", 32'(mem_req_o), 0);
    @(negedge clk);
    check("valid_pulse", 32'(valid_o), 0);
    check("flags_pulse", {30'b0, misalign_o, bus_err_o}, 0);
    check("stall_idle", 32'(stall_o), 0);
    if (have_data) check("wdata_hold", wdata_o, exp_wdata);
  endtask

  initial begin
    rst = 1'b1; valid_i = 0; aluop_i = 0; wd_i = 0; wreg_i = 0; wdata_i = 0; mem_addr_i = 0;
    reg2_i = 0; mem_ack_i = 0; mem_data_i = 0; switch_i = 0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_req", 32'(mem_req_o), 0);
    check("rst_led", 32'(led_o), 0);
    check("rst_sel", 32'(mem_sel_o), 0);
    check("rst_wdata", wdata_o, 0);
    rst = 1'b0;

    do_op(ADDU, 32'h0, 32'h0, 5'd3, 1'b1, 32'h1234_5678, 16'h0, 32'h0, 0);
    check("nonmem_stall", 32'(last_stall), 0);
    do_op(LB, 32'h0000_0001, 32'h0, 5'd4, 1'b1, 32'h0, 16'h0, 32'h1280_FFFF, 1);
    check("lb_wdata", wdata_o, 32'hFFFF_FF80);
    check("lb_stall_cycles", 32'(last_stall), 3);
    do_op(SH, 32'h0000_0002, 32'hAAAA_1234, 5'd5, 1'b1, 32'h0, 16'h0, 32'h0, 0);
    do_op(LW, 32'h0000_0006, 32'h0, 5'd6, 1'b1, 32'h0, 16'h0, 32'h0, 0);
    do_op(SW, 32'h8000_0000, 32'h0000_BEEF, 5'd7, 1'b1, 32'h0, 16'h0, 32'h0, 0);
    check("led_beef", 32'(led_o), 32'hBEEF);
    do_op(LW, 32'h8000_0000, 32'h0, 5'd8, 1'b1, 32'h0, 16'h00A5, 32'h0, 0);
    check("mmio_lw", wdata_o, 32'h0000_00A5);
    do_op(LHU, 32'h0000_0010, 32'h0, 5'd9, 1'b1, 32'h0, 16'h0, 32'h0, -1);
    do_op(LH, 32'h0000_0022, 32'h0, 5'd10, 1'b1, 32'h0, 16'h0, 32'h1234_8001, TIMEOUT);
    check("ack_at_limit", wdata_o, 32'hFFFF_8001);

    // Reset in the second BUSY cycle aborts the load.
    @(negedge clk);
    valid_i = 1'b1; aluop_i = LW; mem_addr_i = 32'h0000_0100; wreg_i = 1'b1;
    @(negedge clk); valid_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("abort_req", 32'(mem_req_o), 0);
    check("abort_valid", 32'(valid_o), 0);
    check("abort_led", 32'(led_o), 0);
    check("abort_outs", {mem_addr_o[27:0], mem_sel_o}, 0);
    check("abort_data", mem_data_o | wdata_o, 0);
    rst = 1'b0; led_m = '0;
    @(negedge clk);
    check("abort_no_valid", 32'(valid_o), 0);
    check("abort_stall", 32'(stall_o), 0);

    for (int i = 0; i < 80; i++) begin
      logic [7:0] op;
      logic [31:0] addr;
      int ack;
      case ($urandom_range(0, 9))
        0: op = LB; 1: op = LBU; 2: op = LH; 3: op = LHU; 4: op = LW;
        5: op = SB; 6: op = SH; 7: op = SW; 8: op = ADDU; default: op = ORI;
      endcase
      addr = $urandom;
      addr[31] = ($urandom_range(0, 3) == 0);
      ack = $urandom_range(0, TIMEOUT + 3);
      do_op(op, addr, $urandom, 5'($urandom), 1'($urandom), $urandom, 16'($urandom), $urandom, ack);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width.
REQ-002 Parameter SWITCH_N, default 16, switch input width; LED_N, default 16, LED output width.
REQ-003 Parameter MMIO_BIT, default ADDR_W-1, address bit selecting I/O space when 1.
REQ-004 Parameter TIMEOUT, default 15, maximum wait cycles for mem_ack_i.
REQ-005 One clock, clk; reset rst is synchronous and active-high.
REQ-006 Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_i  in  1  upstream instruction present
- aluop_i  in  8  op code: EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP; other codes are non-memory
- wd_i  in  5  destination register
- wreg_i  in  1  register write request
- wdata_i  in  32  ALU result
- mem_addr_i  in  ADDR_W  effective address
- reg2_i  in  32  store source
- stall_o  out  1  upstream must hold inputs
- valid_o, wd_o, wreg_o, wdata_o  out  1/5/1/32  registered writeback result
- misalign_o, bus_err_o  out  1  one-cycle exception flags, aligned with valid_o
- mem_req_o, mem_we_o  out  1  bus request, write
- mem_addr_o  out  ADDR_W  word address, low 2 bits zero
- mem_sel_o  out  4  byte enables
- mem_data_o  out  32  store data
- mem_ack_i  in  1  bus completion
- mem_data_i  in  32  load data, valid with mem_ack_i
- switch_i  in  SWITCH_N  input port; led_o  out  LED_N  output register

Function
REQ-007 States: IDLE, BUSY.
REQ-008 IDLE, valid_i, non-memory op: next edge valid_o=1, wd_o/wreg_o/wdata_o = inputs; latency 1.
REQ-009 Misaligned access (halfword addr[0]=1; word addr[1:0]!=0): no bus request; next edge valid_o=1, misalign_o=1, wreg_o=0, led_o unchanged.
REQ-010 MMIO access (addr[MMIO_BIT]=1, aligned): no bus request; load returns switch_i zero-extended to 32; store loads led_o from reg2_i[LED_N-1:0]; latency 1.
REQ-011 Aligned non-MMIO memory op in IDLE: stall_o=1 combinationally; next edge mem_req_o=1, bus fields registered, state BUSY.
REQ-012 Byte lanes big-endian: addr[1:0]=00 selects bits 31:24 (mem_sel_o 4'b1000) ... 11 selects 7:0 (4'b0001); halfword 0x selects 1100, 1x selects 0011; word selects 1111.
REQ-013 Store data: SB {4{reg2_i[7:0]}}, SH {2{reg2_i[15:0]}}, SW reg2_i; mem_we_o=1 for stores only.
REQ-014 BUSY: stall_o=1; mem_req_o and bus fields held constant until ack or timeout.
REQ-015 BUSY with mem_ack_i: next edge mem_req_o=0, valid_o=1, state IDLE; load wdata_o = selected lane, sign-extended for LB/LH, zero-extended for LBU/LHU; store wreg_o=0.
REQ-016 Wait counter clears on entering BUSY and increments each BUSY cycle without ack; ack in the cycle the counter equals TIMEOUT still counts as success.
REQ-017 Counter reaching TIMEOUT without ack: next edge mem_req_o=0, valid_o=1, bus_err_o=1, wreg_o=0, state IDLE.
REQ-018 valid_o, misalign_o, bus_err_o are single-cycle pulses; stall_o=0 in IDLE except per REQ-011.
REQ-019 valid_i=0 in IDLE: valid_o=0 next cycle; other outputs hold.
REQ-020 led_o changes only on MMIO stores or reset.

Reset
REQ-021 rst high at an edge: state IDLE, counter 0, every output 0 (incl. led_o, mem_sel_o).
REQ-022 rst during BUSY aborts the access: mem_req_o=0 after that edge, no valid_o pulse for the aborted op.

Verification
REQ-023 LB addr 0x00000001, ack after 2 cycles with mem_data_i 0x1280FFFF -> mem_sel_o 0100, wdata_o 0xFFFFFF80, stall_o high 3 cycles.
REQ-024 SH addr 0x00000002, reg2_i 0xAAAA1234 -> mem_sel_o 0011, mem_data_o 0x12341234, mem_we_o 1, wreg_o 0.
REQ-025 LW addr 0x00000006 -> misalign_o pulse, mem_req_o never asserted, wreg_o 0.
REQ-026 SW addr 0x80000000, reg2_i 0x0000BEEF -> led_o 0xBEEF, no bus request; LW same addr with switch_i 0x00A5 -> wdata_o 0x000000A5.
REQ-027 LHU with no ack for TIMEOUT+1 cycles -> bus_err_o pulse, mem_req_o drops, state IDLE.
REQ-028 rst asserted in second BUSY cycle -> all outputs 0 next edge, no valid_o for the aborted load.
